// File: rtl/elbeth_pkg.sv
// elbeth_pkg: shared constants and types for the ELBETH fetch unit.
//   PC_SEL_*        next-PC source encodings driven by decode
//   fetch_state_e   fetch FSM state encoding
//   NOP_INSTR       addi x0,x0,0, injected on flush
//   OPCODE_*/FUNCT3_* RISC-V field positions inside an instruction word
//   ifid_t          IF/ID pipeline register contents
package elbeth_pkg;

   localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
   localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
   localparam logic [1:0] PC_SEL_JALR   = 2'b10;
   localparam logic [1:0] PC_SEL_EXC    = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_REQ   = 2'b01,
      ST_HOLD  = 2'b10,
      ST_DRAIN = 2'b11
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam int OPCODE_LSB = 0;
   localparam int OPCODE_MSB = 6;
   localparam int FUNCT3_LSB = 12;
   localparam int FUNCT3_MSB = 14;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        valid;
   } ifid_t;

endpackage

// File: rtl/elbeth_next_pc.sv
// elbeth_next_pc: combinational next-PC logic for the fetch unit.
//   pc            current fetch PC
//   pc_select     next-PC source (see PC_SEL_*)
//   branch_target branch/JAL target
//   jalr_target   JALR target (bit0 is cleared here)
//   seq_pc        pc + 4, wrapping modulo 2^32
//   redirect      pc_select selects a non-sequential source
//   redirect_pc   PC to load on a redirect
//   misaligned    (ELBETH_FETCH_MISALIGN_EN only) redirect target not word aligned
// Macro ELBETH_FETCH_MISALIGN_EN: misaligned targets trap to EXCEPTION_VECTOR
// instead of being silently word-aligned.
module elbeth_next_pc #(
   parameter logic [31:0] EXCEPTION_VECTOR = 32'h0000_0100
) (
   input  logic [31:0] pc,
   input  logic [1:0]  pc_select,
   input  logic [31:0] branch_target,
   input  logic [31:0] jalr_target,
   output logic [31:0] seq_pc,
   output logic        redirect,
`ifdef ELBETH_FETCH_MISALIGN_EN
   output logic        misaligned,
`endif
   output logic [31:0] redirect_pc
);
   import elbeth_pkg::*;

   logic [31:0] target;

   always_comb begin
      target = EXCEPTION_VECTOR;
      case (pc_select)
         PC_SEL_BRANCH: target = branch_target;
         PC_SEL_JALR:   target = {jalr_target[31:1], 1'b0};
         default:       target = EXCEPTION_VECTOR;
      endcase
   end

   assign seq_pc   = pc + 32'd4;
   assign redirect = (pc_select != PC_SEL_SEQ);

`ifdef ELBETH_FETCH_MISALIGN_EN
   assign misaligned  = redirect && (target[1:0] != 2'b00);
   assign redirect_pc = misaligned ? EXCEPTION_VECTOR : target;
`else
   assign redirect_pc = {target[31:2], 2'b00};
`endif

endmodule

// File: rtl/elbeth_fetch_unit.sv
// elbeth_fetch_unit: instruction-fetch stage of the ELBETH RISC-V core.
//   clk, rst          core clock, synchronous active-high reset
//   id_pc_select      next-PC source; ignored while id_stall is high
//   id_branch_target, id_jalr_target   redirect targets
//   if_stall, id_stall  stalls; IF/ID holds while either is high
//   if_imem_*         instruction memory request handshake (en/addr held until ready)
//   if_pc, if_instruction, if_valid   IF/ID register
//   if_opcode, if_funct3  decoded fields for elbeth_control_unit
//   if_misaligned     (ELBETH_FETCH_MISALIGN_EN only) one-cycle pulse on a
//                     misaligned redirect target
// Macro ELBETH_FETCH_MISALIGN_EN enables the misaligned-target trap.
module elbeth_fetch_unit #(
   parameter logic [31:0] RESET_VECTOR     = 32'h0000_0000,
   parameter logic [31:0] EXCEPTION_VECTOR = 32'h0000_0100,
   parameter logic [31:0] NOP_INSTR        = elbeth_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  id_pc_select,
   input  logic [31:0] id_branch_target,
   input  logic [31:0] id_jalr_target,
   input  logic        if_stall,
   input  logic        id_stall,
   output logic [31:0] if_imem_addr,
   output logic        if_imem_en,
   input  logic        if_imem_ready,
   input  logic [31:0] if_imem_data,
   output logic [31:0] if_pc,
   output logic [31:0] if_instruction,
   output logic        if_valid,
`ifdef ELBETH_FETCH_MISALIGN_EN
   output logic        if_misaligned,
`endif
   output logic [6:0]  if_opcode,
   output logic [2:0]  if_funct3
);
   import elbeth_pkg::*;

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  addr_q, addr_d;
   logic         en_q, en_d;
   logic [31:0]  hold_q, hold_d;
   ifid_t        ifid_q, ifid_d;

   logic [31:0]  seq_pc, redirect_pc;
   logic         redirect, stall, take_redirect, handshake;

`ifdef ELBETH_FETCH_MISALIGN_EN
   logic         misaligned;
   logic         mis_q, mis_d;
`endif

   elbeth_next_pc #(.EXCEPTION_VECTOR(EXCEPTION_VECTOR)) u_next_pc (
      .pc            (pc_q),
      .pc_select     (id_pc_select),
      .branch_target (id_branch_target),
      .jalr_target   (id_jalr_target),
      .seq_pc        (seq_pc),
      .redirect      (redirect),
`ifdef ELBETH_FETCH_MISALIGN_EN
      .misaligned    (misaligned),
`endif
      .redirect_pc   (redirect_pc)
   );

   assign stall         = if_stall | id_stall;
   assign take_redirect = redirect & ~id_stall;
   // en_q is high exactly in REQ/DRAIN, so this is the handshake in both.
   assign handshake     = en_q & if_imem_ready;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      hold_d  = hold_q;
      ifid_d  = ifid_q;
`ifdef ELBETH_FETCH_MISALIGN_EN
      mis_d   = 1'b0;
`endif
      // An unstalled cycle with no new word is a bubble: the old word stays
      // visible but must not be executed twice.
      if (!stall) ifid_d.valid = 1'b0;

      case (state_q)
         ST_IDLE: state_d = ST_REQ;
         ST_REQ: begin
            if (handshake) begin
               if (stall) begin
                  hold_d  = if_imem_data;
                  state_d = ST_HOLD;
               end else begin
                  ifid_d.instr = if_imem_data;
                  ifid_d.pc    = pc_q;
                  ifid_d.valid = 1'b1;
                  pc_d         = seq_pc;
               end
            end
         end
         ST_HOLD: begin
            if (!stall) begin
               ifid_d.instr = hold_q;
               ifid_d.pc    = pc_q;
               ifid_d.valid = 1'b1;
               pc_d         = seq_pc;
               state_d      = ST_REQ;
            end
         end
         ST_DRAIN: if (handshake) state_d = ST_REQ;
         default: state_d = ST_IDLE;
      endcase

      // A redirect kills whatever this cycle produced (including a held word)
      // and flushes IF/ID, even under if_stall. A still-outstanding request
      // must run to completion, hence DRAIN.
      if (take_redirect) begin
         pc_d         = redirect_pc;
         ifid_d.instr = NOP_INSTR;
         ifid_d.valid = 1'b0;
         state_d      = (en_q && !if_imem_ready) ? ST_DRAIN : ST_REQ;
`ifdef ELBETH_FETCH_MISALIGN_EN
         mis_d        = misaligned;
`endif
      end

      en_d   = (state_d == ST_REQ) || (state_d == ST_DRAIN);
      // While draining, the bus keeps the old address; pc already holds the target.
      addr_d = (state_d == ST_DRAIN) ? addr_q : pc_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         pc_q         <= RESET_VECTOR;
         addr_q       <= RESET_VECTOR;
         en_q         <= 1'b0;
         hold_q       <= NOP_INSTR;
         ifid_q.pc    <= RESET_VECTOR;
         ifid_q.instr <= NOP_INSTR;
         ifid_q.valid <= 1'b0;
`ifdef ELBETH_FETCH_MISALIGN_EN
         mis_q        <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         en_q    <= en_d;
         hold_q  <= hold_d;
         ifid_q  <= ifid_d;
`ifdef ELBETH_FETCH_MISALIGN_EN
         mis_q   <= mis_d;
`endif
      end
   end

   assign if_imem_addr   = addr_q;
   assign if_imem_en     = en_q;
   assign if_pc          = ifid_q.pc;
   assign if_instruction = ifid_q.instr;
   assign if_valid       = ifid_q.valid;
   assign if_opcode      = ifid_q.instr[OPCODE_MSB:OPCODE_LSB];
   assign if_funct3      = ifid_q.instr[FUNCT3_MSB:FUNCT3_LSB];
`ifdef ELBETH_FETCH_MISALIGN_EN
   assign if_misaligned  = mis_q;
`endif

endmodule

// File: tb/tb_elbeth_fetch_unit.sv
module tb_elbeth_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  id_pc_select;
   logic [31:0] id_branch_target, id_jalr_target;
   logic        if_stall, id_stall;
   logic [31:0] if_imem_addr;
   logic        if_imem_en;
   logic        if_imem_ready;
   logic [31:0] if_imem_data;
   logic [31:0] if_pc, if_instruction;
   logic        if_valid;
   logic [6:0]  if_opcode;
   logic [2:0]  if_funct3;
`ifdef ELBETH_FETCH_MISALIGN_EN
   logic        if_misaligned;
`endif

   int vecs = 0;
   int bad  = 0;

   always #5 clk = ~clk;

   // Instruction memory image: 0x0 -> 0x13, 0x4 -> 0x00A00093, else {addr[23:0],8'h13}.
   function automatic logic [31:0] mem(input logic [31:0] a);
      if (a == 32'h0)      return 32'h0000_0013;
      else if (a == 32'h4) return 32'h00A0_0093;
      else                 return {a[23:0], 8'h13};
   endfunction

   assign if_imem_data = mem(if_imem_addr);

   elbeth_fetch_unit dut (
      .clk(clk), .rst(rst),
      .id_pc_select(id_pc_select), .id_branch_target(id_branch_target),
      .id_jalr_target(id_jalr_target),
      .if_stall(if_stall), .id_stall(id_stall),
      .if_imem_addr(if_imem_addr), .if_imem_en(if_imem_en),
      .if_imem_ready(if_imem_ready), .if_imem_data(if_imem_data),
      .if_pc(if_pc), .if_instruction(if_instruction), .if_valid(if_valid),
`ifdef ELBETH_FETCH_MISALIGN_EN
      .if_misaligned(if_misaligned),
`endif
      .if_opcode(if_opcode), .if_funct3(if_funct3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; id_pc_select = 2'b00; id_branch_target = '0; id_jalr_target = '0;
      if_stall = 1'b0; id_stall = 1'b0; if_imem_ready = 1'b0;
      tick(); tick();
      vecs++; if (if_imem_en !== 1'b0) begin bad++; $display("FAIL reset_en got %b exp 0", if_imem_en); end
      vecs++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b exp 0", if_valid); end
      vecs++; if (if_instruction !== 32'h13) begin bad++; $display("FAIL reset_instr got %h exp 00000013", if_instruction); end
      vecs++; if (if_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got %h exp 0", if_pc); end
   endtask

   task automatic test_stream();
      rst = 1'b0; if_imem_ready = 1'b1;
      vecs++; if (if_imem_en !== 1'b0) begin bad++; $display("FAIL idle_en got %b exp 0", if_imem_en); end
      tick();
      vecs++; if (if_imem_en !== 1'b1 || if_imem_addr !== 32'h0) begin bad++; $display("FAIL req0 got en=%b addr=%h exp en=1 addr=0", if_imem_en, if_imem_addr); end
      vecs++; if (if_valid !== 1'b0) begin bad++; $display("FAIL req0_valid got %b exp 0", if_valid); end
      tick();
      vecs++; if (if_imem_addr !== 32'h4) begin bad++; $display("FAIL stream_addr4 got %h exp 4", if_imem_addr); end
      vecs++; if (if_valid !== 1'b1 || if_instruction !== 32'h13 || if_pc !== 32'h0) begin bad++; $display("FAIL stream_w0 got v=%b i=%h pc=%h exp v=1 i=13 pc=0", if_valid, if_instruction, if_pc); end
      vecs++; if (if_opcode !== 7'h13) begin bad++; $display("FAIL stream_opcode got %h exp 13", if_opcode); end
      tick();
      vecs++; if (if_imem_addr !== 32'h8) begin bad++; $display("FAIL stream_addr8 got %h exp 8", if_imem_addr); end
      vecs++; if (if_instruction !== 32'h00A00093 || if_pc !== 32'h4) begin bad++; $display("FAIL stream_w1 got i=%h pc=%h exp i=00a00093 pc=4", if_instruction, if_pc); end
   endtask

   task automatic test_wait();
      if_imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vecs++; if (if_imem_en !== 1'b1 || if_imem_addr !== 32'h8) begin bad++; $display("FAIL wait_req%0d got en=%b addr=%h exp en=1 addr=8", i, if_imem_en, if_imem_addr); end
         vecs++; if (if_instruction !== 32'h00A00093) begin bad++; $display("FAIL wait_instr%0d got %h exp 00a00093", i, if_instruction); end
         tick();
      end
      if_imem_ready = 1'b1;
      vecs++; if (if_imem_en !== 1'b1 || if_imem_addr !== 32'h8) begin bad++; $display("FAIL wait_req3 got en=%b addr=%h exp en=1 addr=8", if_imem_en, if_imem_addr); end
      tick();
      vecs++; if (if_instruction !== 32'h00000813 || if_pc !== 32'h8 || if_valid !== 1'b1) begin bad++; $display("FAIL wait_done got i=%h pc=%h v=%b exp i=00000813 pc=8 v=1", if_instruction, if_pc, if_valid); end
      vecs++; if (if_imem_addr !== 32'hC) begin bad++; $display("FAIL wait_next got %h exp c", if_imem_addr); end
   endtask

   task automatic test_id_stall_hold();
      id_stall = 1'b1;               // handshake at 0xC under stall
      tick();
      vecs++; if (if_imem_en !== 1'b0) begin bad++; $display("FAIL hold_en1 got %b exp 0", if_imem_en); end
      vecs++; if (if_instruction !== 32'h00000813 || if_pc !== 32'h8) begin bad++; $display("FAIL hold_ifid1 got i=%h pc=%h exp i=00000813 pc=8", if_instruction, if_pc); end
      tick();
      id_stall = 1'b0;
      vecs++; if (if_imem_en !== 1'b0 || if_instruction !== 32'h00000813) begin bad++; $display("FAIL hold_ifid2 got en=%b i=%h exp en=0 i=00000813", if_imem_en, if_instruction); end
      tick();
      vecs++; if (if_instruction !== 32'h00000C13 || if_pc !== 32'hC || if_valid !== 1'b1) begin bad++; $display("FAIL hold_release got i=%h pc=%h v=%b exp i=00000c13 pc=c v=1", if_instruction, if_pc, if_valid); end
      vecs++; if (if_imem_en !== 1'b1 || if_imem_addr !== 32'h10) begin bad++; $display("FAIL hold_next got en=%b addr=%h exp en=1 addr=10", if_imem_en, if_imem_addr); end
   endtask

   task automatic test_redirect_drain();
      if_imem_ready = 1'b0; id_pc_select = 2'b01; id_branch_target = 32'h40;
      tick();
      id_pc_select = 2'b00;
      vecs++; if (if_imem_en !== 1'b1 || if_imem_addr !== 32'h10) begin bad++; $display("FAIL drain_hold got en=%b addr=%h exp en=1 addr=10", if_imem_en, if_imem_addr); end
      vecs++; if (if_valid !== 1'b0 || if_instruction !== 32'h13) begin bad++; $display("FAIL drain_flush got v=%b i=%h exp v=0 i=13", if_valid, if_instruction); end
      tick();
      vecs++; if (if_imem_addr !== 32'h10) begin bad++; $display("FAIL drain_hold2 got %h exp 10", if_imem_addr); end
      if_imem_ready = 1'b1;
      tick();
      vecs++; if (if_imem_addr !== 32'h40 || if_imem_en !== 1'b1) begin bad++; $display("FAIL drain_target got en=%b addr=%h exp en=1 addr=40", if_imem_en, if_imem_addr); end
      vecs++; if (if_valid !== 1'b0 || if_instruction !== 32'h13) begin bad++; $display("FAIL drain_discard got v=%b i=%h exp v=0 i=13", if_valid, if_instruction); end
      tick();
      vecs++; if (if_instruction !== 32'h00004013 || if_pc !== 32'h40 || if_funct3 !== 3'd4) begin bad++; $display("FAIL drain_w40 got i=%h pc=%h f3=%0d exp i=00004013 pc=40 f3=4", if_instruction, if_pc, if_funct3); end
   endtask

   task automatic test_jalr();
      id_pc_select = 2'b10; id_jalr_target = 32'h81;  // handshake at 0x44 discarded
      tick();
      id_pc_select = 2'b00;
      vecs++; if (if_imem_addr !== 32'h80 || if_valid !== 1'b0 || if_instruction !== 32'h13) begin bad++; $display("FAIL jalr got addr=%h v=%b i=%h exp addr=80 v=0 i=13", if_imem_addr, if_valid, if_instruction); end
   endtask

   task automatic test_stalled_select_ignored();
      if_imem_ready = 1'b0; id_stall = 1'b1; id_pc_select = 2'b01; id_branch_target = 32'h200;
      tick();
      id_stall = 1'b0; id_pc_select = 2'b00; if_imem_ready = 1'b1;
      vecs++; if (if_imem_addr !== 32'h80 || if_imem_en !== 1'b1) begin bad++; $display("FAIL sel_ignored got en=%b addr=%h exp en=1 addr=80", if_imem_en, if_imem_addr); end
      tick();
      vecs++; if (if_instruction !== 32'h00008013 || if_pc !== 32'h80 || if_imem_addr !== 32'h84) begin bad++; $display("FAIL sel_ignored_w got i=%h pc=%h addr=%h exp i=00008013 pc=80 addr=84", if_instruction, if_pc, if_imem_addr); end
   endtask

   task automatic test_if_stall();
      if_stall = 1'b1;
      tick();
      if_stall = 1'b0;
      vecs++; if (if_imem_en !== 1'b0 || if_instruction !== 32'h00008013) begin bad++; $display("FAIL ifstall_hold got en=%b i=%h exp en=0 i=00008013", if_imem_en, if_instruction); end
      tick();
      vecs++; if (if_instruction !== 32'h00008413 || if_pc !== 32'h84 || if_imem_addr !== 32'h88) begin bad++; $display("FAIL ifstall_release got i=%h pc=%h addr=%h exp i=00008413 pc=84 addr=88", if_instruction, if_pc, if_imem_addr); end
   endtask

   task automatic test_misalign();
      id_pc_select = 2'b01; id_branch_target = 32'h42;
      tick();
      id_pc_select = 2'b00;
`ifdef ELBETH_FETCH_MISALIGN_EN
      vecs++; if (if_imem_addr !== 32'h100 || if_misaligned !== 1'b1) begin bad++; $display("FAIL misalign_trap got addr=%h mis=%b exp addr=100 mis=1", if_imem_addr, if_misaligned); end
      tick();
      vecs++; if (if_misaligned !== 1'b0 || if_instruction !== 32'h00010013) begin bad++; $display("FAIL misalign_pulse got mis=%b i=%h exp mis=0 i=00010013", if_misaligned, if_instruction); end
`else
      vecs++; if (if_imem_addr !== 32'h40) begin bad++; $display("FAIL misalign_force got addr=%h exp 40", if_imem_addr); end
      tick();
      vecs++; if (if_instruction !== 32'h00004013 || if_pc !== 32'h40) begin bad++; $display("FAIL misalign_word got i=%h pc=%h exp i=00004013 pc=40", if_instruction, if_pc); end
`endif
   endtask

   task automatic test_wrap_and_reset();
      id_pc_select = 2'b01; id_branch_target = 32'hFFFF_FFFC;
      tick();
      id_pc_select = 2'b00;
      vecs++; if (if_imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_req got %h exp fffffffc", if_imem_addr); end
      tick();
      vecs++; if (if_imem_addr !== 32'h0 || if_instruction !== 32'hFFFF_FC13 || if_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap got addr=%h i=%h pc=%h exp addr=0 i=fffffc13 pc=fffffffc", if_imem_addr, if_instruction, if_pc); end
      if_imem_ready = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0; if_imem_ready = 1'b1;   // stale ready must not be taken
      vecs++; if (if_imem_en !== 1'b0 || if_imem_addr !== 32'h0 || if_valid !== 1'b0 || if_instruction !== 32'h13) begin bad++; $display("FAIL midreset got en=%b addr=%h v=%b i=%h exp en=0 addr=0 v=0 i=13", if_imem_en, if_imem_addr, if_valid, if_instruction); end
      tick();
      vecs++; if (if_imem_en !== 1'b1 || if_imem_addr !== 32'h0 || if_valid !== 1'b0) begin bad++; $display("FAIL postreset_req got en=%b addr=%h v=%b exp en=1 addr=0 v=0", if_imem_en, if_imem_addr, if_valid); end
      tick();
      vecs++; if (if_valid !== 1'b1 || if_instruction !== 32'h13 || if_imem_addr !== 32'h4) begin bad++; $display("FAIL postreset_w0 got v=%b i=%h addr=%h exp v=1 i=13 addr=4", if_valid, if_instruction, if_imem_addr); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_wait();
      test_id_stall_hold();
      test_redirect_drain();
      test_jalr();
      test_stalled_select_ignored();
      test_if_stall();
      test_misalign();
      test_wrap_and_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
      $finish;
   end

endmodule
